// File: rtl/noc_ram_responder.sv
// noc_ram_responder: memory-server endpoint of the NoC load/store protocol.
// Queues incoming request packets, performs one access at a time on a
// single-port synchronous RAM and returns read-data, write-ack or error
// packets in request order.
//
// Optional feature macro: NOC_RESP_WRITE_ACK_EN
//   defined   -> every in-range write is answered with a 4'h4 ack packet
//   undefined -> writes are posted (no response packet)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; a producer holds valid and its payload stable until that edge,
// and ready never depends combinationally on valid.
module noc_ram_responder #(
  parameter int NODE_ID         = 0,
  parameter int NODE_COUNT      = 9,
  parameter int RAM_CHUNK_SIZE  = 1024,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int REQ_FIFO_DEPTH  = 4,
  localparam int NW = $clog2(NODE_COUNT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [67:0]                req_packet,
  input  logic [NW-1:0]              req_node_start,
  input  logic [PACKET_ID_WIDTH-1:0] req_packet_id,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [67:0]                rsp_packet,
  output logic [NW-1:0]              rsp_node_dest,
  output logic [PACKET_ID_WIDTH-1:0] rsp_packet_id,
  output logic [31:0]                ram_address,
  output logic [31:0]                wr_data,
  output logic                       we,
  input  logic [31:0]                rd_data
);

  localparam int PW = PACKET_ID_WIDTH;
  localparam int EW = 68 + NW + PW;
  localparam int AW = $clog2(REQ_FIFO_DEPTH);
  localparam logic [31:0] BASE     = 32'(NODE_ID * RAM_CHUNK_SIZE);
  localparam logic [31:0] LIMIT    = 32'(RAM_CHUNK_SIZE);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(REQ_FIFO_DEPTH);

  localparam logic [3:0] OP_READ  = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;
  localparam logic [3:0] OP_RDATA = 4'h3;
  localparam logic [3:0] OP_ACK   = 4'h4;
  localparam logic [3:0] OP_ERR   = 4'hF;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

`ifdef NOC_RESP_WRITE_ACK_EN
  localparam state_t WRITE_NEXT = RESP;
`else
  localparam state_t WRITE_NEXT = IDLE;
`endif

  // Current FSM state; kept as a named enum so checkers can bind to it.
  state_t state;
  state_t state_nxt;

  // Request FIFO: entry = {packet, node_start, packet_id}
  logic [EW-1:0] fifo_mem [REQ_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // Decoded FIFO head
  logic [EW-1:0] head;
  logic [67:0]   head_packet;
  logic [3:0]    head_op;
  logic [31:0]   head_addr;
  logic [31:0]   head_phys;
  logic [NW-1:0] head_node;
  logic [PW-1:0] head_id;
  logic          head_ok;

  // Working registers of the request in service
  logic [31:0] work_addr;
  logic        work_write;

  assign req_ready = (count != FULL_CNT);
  assign push      = req_valid && req_ready;

  assign head        = fifo_mem[rd_ptr];
  assign head_packet = head[EW-1 -: 68];
  assign head_node   = head[PW +: NW];
  assign head_id     = head[PW-1:0];
  assign head_op     = head_packet[67:64];
  assign head_addr   = head_packet[63:32];
  // Unsigned subtraction: addresses below the chunk base wrap to huge values
  // and therefore fail the range test as well.
  assign head_phys   = head_addr - BASE;
  assign head_ok     = ((head_op == OP_READ) || (head_op == OP_WRITE)) &&
                       (head_phys < LIMIT);

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_packet, req_node_start, req_packet_id};
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and FIFO pop decision.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = head_ok ? ACCESS : RESP;
        end
      end
      ACCESS:  state_nxt = work_write ? WRITE_NEXT : CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: RAM port is registered at pop time so the access is visible
  // during ACCESS; response fields are loaded once and held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid     <= 1'b0;
      rsp_packet    <= '0;
      rsp_node_dest <= '0;
      rsp_packet_id <= '0;
      ram_address   <= '0;
      wr_data       <= '0;
      we            <= 1'b0;
      work_addr     <= '0;
      work_write    <= 1'b0;
    end else begin
      if (pop) begin
        work_addr     <= head_addr;
        work_write    <= (head_op == OP_WRITE);
        rsp_node_dest <= head_node;
        rsp_packet_id <= head_id;
        if (head_ok) begin
          ram_address <= head_phys;
          we          <= (head_op == OP_WRITE);
          if (head_op == OP_WRITE) wr_data <= head_packet[31:0];
        end else begin
          rsp_valid  <= 1'b1;
          rsp_packet <= {OP_ERR, head_addr, 32'h0};
        end
      end
      if (state == ACCESS) begin
        we <= 1'b0;
`ifdef NOC_RESP_WRITE_ACK_EN
        if (work_write) begin
          rsp_valid  <= 1'b1;
          rsp_packet <= {OP_ACK, work_addr, 32'h0};
        end
`endif
      end
      if (state == CAPTURE) begin
        rsp_valid  <= 1'b1;
        rsp_packet <= {OP_RDATA, work_addr, rd_data};
      end
      if ((state == RESP) && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_ram_responder.sv
// Testbench for noc_ram_responder (NODE_ID=1, chunk 1024 words, depth 4).
// A behavioural RAM sits on the DUT's RAM port; the reference model keeps its
// own copy of memory and predicts responses and RAM writes at acceptance time.
module tb_noc_ram_responder;

  localparam int NW  = 4;
  localparam int PW  = 5;
  localparam int RW  = 68 + NW + PW;
  localparam int CHUNK = 1024;
  localparam logic [31:0] BASE = 32'd1024;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [67:0]   req_packet = '0;
  logic [NW-1:0] req_node_start = '0;
  logic [PW-1:0] req_packet_id = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [67:0]   rsp_packet;
  logic [NW-1:0] rsp_node_dest;
  logic [PW-1:0] rsp_packet_id;
  logic [31:0]   ram_address;
  logic [31:0]   wr_data;
  logic          we;
  logic [31:0]   rd_data;

  noc_ram_responder #(
    .NODE_ID(1), .NODE_COUNT(9), .RAM_CHUNK_SIZE(CHUNK),
    .PACKET_ID_WIDTH(PW), .REQ_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_packet(req_packet),
    .req_node_start(req_node_start), .req_packet_id(req_packet_id),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_packet(rsp_packet),
    .rsp_node_dest(rsp_node_dest), .rsp_packet_id(rsp_packet_id),
    .ram_address(ram_address), .wr_data(wr_data), .we(we), .rd_data(rd_data)
  );

  // behavioural single-port synchronous RAM (environment, not the model)
  logic [31:0] ram [CHUNK];
  always @(posedge clk) begin
    if (we) ram[ram_address[9:0]] <= wr_data;
    rd_data <= ram[ram_address[9:0]];
  end

  // reference model state and scoreboard
  logic [31:0] mmem [CHUNK];
  logic [RW-1:0] exp_q[$];
  logic [63:0]   wexp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Spec-level prediction of one accepted request.
  task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [NW-1:0] node, input logic [PW-1:0] id);
    logic [31:0] phys;
    bit inr;
    phys = addr - BASE;
    inr = (phys < CHUNK);
    if (op == 4'h1 && inr) begin
      exp_q.push_back({4'h3, addr, mmem[phys[9:0]], node, id});
    end else if (op == 4'h2 && inr) begin
      mmem[phys[9:0]] = data;
      wexp_q.push_back({phys, data});
`ifdef NOC_RESP_WRITE_ACK_EN
      exp_q.push_back({4'h4, addr, 32'h0, node, id});
`endif
    end else begin
      exp_q.push_back({4'hF, addr, 32'h0, node, id});
    end
  endtask

  // driver: present one request, wait up to budget cycles for acceptance
  task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                      input logic [NW-1:0] node, input logic [PW-1:0] id,
                      input int budget, output bit ok);
    logic rdy;
    int n;
    req_packet = {op, addr, data};
    req_node_start = node;
    req_packet_id = id;
    req_valid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      n++;
      if (rdy) ok = 1'b1;
    end
    #1;
    req_valid = 1'b0;
    if (ok) model(op, addr, data, node, id);
  endtask

  // cycles from the acceptance edge until rsp_valid rises (call right after send)
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // response monitor: order, content and stability under backpressure
  logic          prev_stall = 1'b0;
  logic [RW-1:0] prev_rsp;
  always @(negedge clk) begin
    logic [RW-1:0] cur;
    cur = {rsp_packet, rsp_node_dest, rsp_packet_id};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("valid_held", rsp_valid, 1'b1);
        check("stable", cur, prev_rsp);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("unexpected_rsp", cur, '0);
        else check("rsp", cur, exp_q.pop_front());
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_rsp = cur;
    end
  end

  // RAM write monitor: every we cycle must be a predicted write
  always @(negedge clk) begin
    if (rst_n && we) begin
      if (wexp_q.size() == 0) check("unexpected_we", {ram_address, wr_data}, '0);
      else check("ram_write", {ram_address, wr_data}, wexp_q.pop_front());
    end
  end

  // random backpressure
  always @(posedge clk) begin
    if (rand_ready) begin
      #2;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int lat;
    int acc;
    logic [3:0] op;
    logic [31:0] addr;
    int s;

    for (int i = 0; i < CHUNK; i++) begin
      ram[i] = 32'(i) * 32'h9E3779B1;
      mmem[i] = 32'(i) * 32'h9E3779B1;
    end
    ram[5] = 32'hDEADBEEF;
    mmem[5] = 32'hDEADBEEF;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_packet", rsp_packet, 68'h0);
    check("rst_rsp_dest", rsp_node_dest, 4'h0);
    check("rst_rsp_id", rsp_packet_id, 5'h0);
    check("rst_ram_address", ram_address, 32'h0);
    check("rst_wr_data", wr_data, 32'h0);
    check("rst_we", we, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(2);

    // preloaded read with latency
    send(4'h1, 32'd1029, 32'h0, 4'd3, 5'd7, 10, ok);
    check("acc_read", ok, 1'b1);
    wait_rsp(lat);
    check("lat_read", lat, 4);
    idle(3);

    // write then read back
    send(4'h2, 32'd1024, 32'h12345678, 4'd2, 5'd1, 10, ok);
`ifdef NOC_RESP_WRITE_ACK_EN
    wait_rsp(lat);
    check("lat_ack", lat, 3);
`endif
    idle(3);
    send(4'h1, 32'd1024, 32'h0, 4'd2, 5'd2, 10, ok);
    idle(6);
    check("ram_updated", ram[0], 32'h12345678);

    // errors: below chunk and unknown opcode
    send(4'h1, 32'd5, 32'h0, 4'd4, 5'd9, 10, ok);
    wait_rsp(lat);
    check("lat_err", lat, 2);
    idle(3);
    send(4'h7, 32'd1030, 32'hFFFF0000, 4'd8, 5'd31, 10, ok);
    wait_rsp(lat);
    check("lat_err_op", lat, 2);
    idle(3);

    // posted/acked writes followed by one read
    send(4'h2, 32'd1100, 32'hA1, 4'd1, 5'd3, 10, ok);
    send(4'h2, 32'd1101, 32'hA2, 4'd1, 5'd4, 10, ok);
    send(4'h2, 32'd1100, 32'hA3, 4'd1, 5'd5, 10, ok);
    send(4'h1, 32'd1100, 32'h0, 4'd1, 5'd6, 10, ok);
    idle(12);
    check("ram_1100", ram[76], 32'hA3);
    check("ram_1101", ram[77], 32'hA2);

    // backpressure: 1 in service + 4 queued, sixth refused
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      send(4'h1, BASE + 32'($urandom_range(0, CHUNK - 1)), 32'h0, 4'(i), 5'(i + 10), 3, ok);
      if (ok) acc++;
    end
    send(4'h1, 32'd1500, 32'h0, 4'd6, 5'd20, 3, ok);
    check("bp_accepted", acc, 5);
    check("bp_sixth_refused", ok, 1'b0);
    idle(2);
    check("bp_req_ready", req_ready, 1'b0);
    check("bp_rsp_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    send(4'h1, 32'd1500, 32'h0, 4'd6, 5'd20, 20, ok);
    check("bp_sixth_late", ok, 1'b1);
    idle(30);
    check("bp_drained", exp_q.size(), 0);

    // reset while in RESP with queued requests
    rsp_ready = 1'b0;
    send(4'h1, 32'd1030, 32'h0, 4'd5, 5'd1, 10, ok);
    send(4'h1, 32'd1031, 32'h0, 4'd5, 5'd2, 10, ok);
    send(4'h1, 32'd1032, 32'h0, 4'd5, 5'd3, 10, ok);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rr_in_resp", rsp_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    wexp_q.delete();
    #1;
    check("rr_rsp_valid", rsp_valid, 1'b0);
    check("rr_req_ready", req_ready, 1'b1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(12);
    check("rr_no_stale", rsp_valid, 1'b0);

    // randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      s = $urandom_range(0, 9);
      op = (s < 4) ? 4'h1 : (s < 8) ? 4'h2 : (s == 8) ? 4'h7 : 4'($urandom_range(0, 15));
      s = $urandom_range(0, 9);
      case (s)
        0: addr = $urandom;
        1: addr = 32'd1023;
        2: addr = 32'd2048;
        3: addr = 32'd1024;
        4: addr = 32'd2047;
        default: addr = BASE + 32'($urandom_range(0, 63));
      endcase
      send(op, addr, $urandom, 4'($urandom_range(0, 8)), 5'($urandom_range(0, 31)), 60, ok);
      if (!ok) check("rand_accept", ok, 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
    end
    rand_ready = 1'b0;
    #3;
    rsp_ready = 1'b1;
    lat = 0;
    while ((exp_q.size() != 0 || wexp_q.size() != 0) && lat < 500) begin
      @(posedge clk);
      lat++;
    end
    idle(5);
    check("final_rsp_q", exp_q.size(), 0);
    check("final_we_q", wexp_q.size(), 0);
    for (int i = 0; i < 64; i++) begin
      if (ram[i] !== mmem[i]) check("final_ram", ram[i], mmem[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
